// File: rtl/rtc_time_reader.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_time_reader
//  Description : Periodic / on-demand reader of a DS1307-class RTC through an
//                I2C master command interface. Each read writes the register
//                pointer (0), reads seconds/minutes/hours, validates the BCD
//                and publishes binary time.
//  Ports       : clock, reset          - single clock domain, sync active-high
//                pollNow               - one-cycle immediate-read request
//                i2c*  (out)           - command interface to the I2C master
//                i2c*  (in)            - read data and status from the master
//                seconds/minutes/hours - published binary time
//                timeUpdated           - one-cycle pulse with new time
//                busy, i2cError, dataError, rtcHalted - status
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_time_reader #(
  parameter int         ClockFrequency = 1000000,
  parameter int         PollPeriodMs   = 1000,
  parameter int         StartTimeoutMs = 3,
  parameter logic [6:0] RtcAddress     = 7'h68,
  parameter int         MaxBytesToSend = 16,
  parameter int         MaxBytesToRead = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              pollNow,
  output logic                              i2cStart,
  output logic [6:0]                        i2cAddress,
  output logic [$clog2(MaxBytesToSend):0]   i2cNrOfBytesToSend,
  output logic [MaxBytesToSend*8-1:0]       i2cBytesToSend,
  output logic [$clog2(MaxBytesToRead):0]   i2cNrOfBytesToRead,
  input  logic [MaxBytesToRead*8-1:0]       i2cBytesToRead,
  input  logic                              i2cReady,
  input  logic                              i2cClockStretchTimeoutReached,
  input  logic                              i2cNoAcknowledge,
  output logic [5:0]                        seconds,
  output logic [5:0]                        minutes,
  output logic [4:0]                        hours,
  output logic                              timeUpdated,
  output logic                              busy,
  output logic                              i2cError,
  output logic                              dataError,
  output logic                              rtcHalted
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_POLL_COUNT  = (ClockFrequency / 1000) * PollPeriodMs - 1;
  localparam int c_POLL_W      = (c_POLL_COUNT > 0) ? $clog2(c_POLL_COUNT + 1) : 1;
  localparam int c_START_COUNT = StartTimeoutMs * ClockFrequency / 1000;
  localparam int c_START_W     = (c_START_COUNT > 1) ? $clog2(c_START_COUNT) : 1;
  localparam int c_SEND_W      = $clog2(MaxBytesToSend) + 1;
  localparam int c_READ_W      = $clog2(MaxBytesToRead) + 1;

  localparam logic [c_POLL_W-1:0]  c_POLL_LOAD  = c_POLL_W'(c_POLL_COUNT);
  // The pulse cycle is the first WaitBusy cycle, so loading N-1 makes the
  // timeout flag appear exactly N cycles after the start pulse.
  localparam logic [c_START_W-1:0] c_START_LOAD = c_START_W'(c_START_COUNT - 1);

  // --------------------------------------------------------------------------
  // Constant command outputs: write pointer 0, then read 3 bytes
  // --------------------------------------------------------------------------
  assign i2cAddress         = RtcAddress;
  assign i2cNrOfBytesToSend = c_SEND_W'(1);
  assign i2cBytesToSend     = '0;
  assign i2cNrOfBytesToRead = c_READ_W'(3);

  // --------------------------------------------------------------------------
  // BCD decode and validation (first received byte lands in the highest slot)
  // --------------------------------------------------------------------------
  logic [7:0] w_secByte;
  logic [7:0] w_minByte;
  logic [7:0] w_hourByte;
  logic [6:0] w_secBin;
  logic [6:0] w_minBin;
  logic [5:0] w_hourBin;
  logic       w_dataValid;

  assign w_secByte  = i2cBytesToRead[23:16];
  assign w_minByte  = i2cBytesToRead[15:8];
  assign w_hourByte = i2cBytesToRead[7:0];

  // Seconds bit 7 is CH (clock halt); it is not part of the tens digit.
  assign w_secBin  = 7'(w_secByte[6:4]) * 7'd10 + 7'(w_secByte[3:0]);
  assign w_minBin  = 7'(w_minByte[6:4]) * 7'd10 + 7'(w_minByte[3:0]);
  assign w_hourBin = 6'(w_hourByte[5:4]) * 6'd10 + 6'(w_hourByte[3:0]);

  // Tens fields are at most 3 bits wide and can never exceed 9 on their own;
  // the range checks on the binary values cover them.
  assign w_dataValid = (w_secByte[3:0]  <= 4'd9)
                    && (w_minByte[3:0]  <= 4'd9)
                    && (w_hourByte[3:0] <= 4'd9)
                    && (w_secBin  <= 7'd59)
                    && (w_minBin  <= 7'd59)
                    && (w_hourBin <= 6'd23)
                    && !w_hourByte[6];          // 12h mode is rejected

  // Bits intentionally ignored by the decoder.
  logic w_unusedReadBits;
  if (MaxBytesToRead > 3) begin : g_extraReadBytes
    assign w_unusedReadBits = ^{i2cBytesToRead[MaxBytesToRead*8-1:24],
                                w_minByte[7], w_hourByte[7]};
  end else begin : g_noExtraReadBytes
    assign w_unusedReadBits = w_minByte[7] ^ w_hourByte[7];
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQUEST   = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CHECK     = 3'd4,
    ST_DECODE    = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_POLL_W-1:0]  r_pollCounter;
  logic [c_START_W-1:0] r_startCounter;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_pollCounter  <= '0;
      r_startCounter <= '0;
      i2cStart       <= 1'b0;
      timeUpdated    <= 1'b0;
      busy           <= 1'b0;
      i2cError       <= 1'b0;
      dataError      <= 1'b0;
      rtcHalted      <= 1'b0;
      seconds        <= '0;
      minutes        <= '0;
      hours          <= '0;
    end else begin
      i2cStart    <= 1'b0;
      timeUpdated <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // pollNow coinciding with the counter expiry yields one request.
          if ((r_pollCounter == '0) || pollNow) begin
            r_state <= ST_REQUEST;
            busy    <= 1'b1;
          end else begin
            r_pollCounter <= r_pollCounter - 1'b1;
          end
        end

        ST_REQUEST: begin
          i2cStart       <= 1'b1;
          r_startCounter <= c_START_LOAD;
          r_state        <= ST_WAIT_BUSY;
        end

        ST_WAIT_BUSY: begin
          // The master only samples start on its own tick, so ready may stay
          // high for a while; it may also already be low (another user), in
          // which case the pulse still counts as issued.
          if (!i2cReady) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_startCounter == '0) begin
            i2cError      <= 1'b1;
            busy          <= 1'b0;
            r_pollCounter <= c_POLL_LOAD;
            r_state       <= ST_IDLE;
          end else begin
            r_startCounter <= r_startCounter - 1'b1;
          end
        end

        ST_WAIT_DONE: begin
          // No local timeout: the master bounds its own transaction.
          if (i2cReady) begin
            r_state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (i2cNoAcknowledge || i2cClockStretchTimeoutReached) begin
            i2cError      <= 1'b1;
            busy          <= 1'b0;
            r_pollCounter <= c_POLL_LOAD;
            r_state       <= ST_IDLE;
          end else begin
            r_state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          i2cError <= 1'b0;
          if (w_dataValid) begin
            dataError   <= 1'b0;
            seconds     <= w_secBin[5:0];
            minutes     <= w_minBin[5:0];
            hours       <= w_hourBin[4:0];
            rtcHalted   <= w_secByte[7];
            timeUpdated <= 1'b1;
          end else begin
            dataError <= 1'b1;
          end
          busy          <= 1'b0;
          r_pollCounter <= c_POLL_LOAD;
          r_state       <= ST_IDLE;
        end

        default: begin
          busy          <= 1'b0;
          r_pollCounter <= c_POLL_LOAD;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtc_time_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_rtc_time_reader
//  Description : Self-checking bench for rtc_time_reader with a behavioural
//                I2C master / RTC model and a queue of expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_time_reader;

  logic         clock = 1'b0;
  logic         reset;
  logic         pollNow;
  logic         i2cStart;
  logic [6:0]   i2cAddress;
  logic [4:0]   i2cNrOfBytesToSend;
  logic [127:0] i2cBytesToSend;
  logic [4:0]   i2cNrOfBytesToRead;
  logic [127:0] i2cBytesToRead;
  logic         i2cReady;
  logic         i2cClockStretchTimeoutReached;
  logic         i2cNoAcknowledge;
  logic [5:0]   seconds;
  logic [5:0]   minutes;
  logic [4:0]   hours;
  logic         timeUpdated;
  logic         busy;
  logic         i2cError;
  logic         dataError;
  logic         rtcHalted;

  rtc_time_reader #(
    .ClockFrequency(1000000),
    .PollPeriodMs  (2),
    .StartTimeoutMs(3),
    .RtcAddress    (7'h68),
    .MaxBytesToSend(16),
    .MaxBytesToRead(16)
  ) dut (
    .clock                        (clock),
    .reset                        (reset),
    .pollNow                      (pollNow),
    .i2cStart                     (i2cStart),
    .i2cAddress                   (i2cAddress),
    .i2cNrOfBytesToSend           (i2cNrOfBytesToSend),
    .i2cBytesToSend               (i2cBytesToSend),
    .i2cNrOfBytesToRead           (i2cNrOfBytesToRead),
    .i2cBytesToRead               (i2cBytesToRead),
    .i2cReady                     (i2cReady),
    .i2cClockStretchTimeoutReached(i2cClockStretchTimeoutReached),
    .i2cNoAcknowledge             (i2cNoAcknowledge),
    .seconds                      (seconds),
    .minutes                      (minutes),
    .hours                        (hours),
    .timeUpdated                  (timeUpdated),
    .busy                         (busy),
    .i2cError                     (i2cError),
    .dataError                    (dataError),
    .rtcHalted                    (rtcHalted)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int nTests = 0;
  int nFail  = 0;

  // Model configuration
  logic [7:0] cfgSec = 8'h00, cfgMin = 8'h00, cfgHr = 8'h00;
  int         cfgDelay = 2, cfgLen = 8;
  bit         cfgNack = 0, cfgStretch = 0, cfgNoBusy = 0;

  int pulseCount   = 0;
  int lastPulseCyc = -1;
  int lastIdleCyc  = 0;

  // Expected packed result: {seconds, minutes, hours, rtcHalted, timeUpdated, i2cError, dataError}
  logic [20:0] sb[$];

  // Current published time as the bench understands it
  int curS = 0, curM = 0, curH = 0;
  bit curHalt = 0;

  function automatic logic [20:0] mkExp(input int s, input int m, input int h,
                                        input bit halt, input bit upd,
                                        input bit ierr, input bit derr);
    return {6'(s), 6'(m), 5'(h), halt, upd, ierr, derr};
  endfunction

  function automatic logic [20:0] obs();
    return {seconds, minutes, hours, rtcHalted, timeUpdated, i2cError, dataError};
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic poll_now();
    pollNow = 1'b1;
    tick();
    pollNow = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (!busy && n < budget) begin tick(); n++; end
    while (busy && n < budget) begin tick(); n++; end
    ok = (n < budget) && !busy;
    lastIdleCyc = cyc;
  endtask

  task automatic wait_pulse(input int p0, input int budget);
    int n = 0;
    while (pulseCount == p0 && n < budget) begin tick(); n++; end
  endtask

  // I2C master + RTC model, plus start-pulse monitor (acts on negedge)
  initial begin
    int mdlState = 0;
    int mdlCnt   = 0;
    i2cReady = 1'b1;
    i2cNoAcknowledge = 1'b0;
    i2cClockStretchTimeoutReached = 1'b0;
    i2cBytesToRead = {{104{1'b1}}, 24'h0};
    forever begin
      @(negedge clock);
      if (reset) begin
        i2cReady = 1'b1;
        i2cNoAcknowledge = 1'b0;
        i2cClockStretchTimeoutReached = 1'b0;
        mdlState = 0;
      end else begin
        if (i2cStart) begin
          pulseCount++;
          lastPulseCyc = cyc;
        end
        case (mdlState)
          0: if (i2cStart && !cfgNoBusy) begin
               mdlCnt = cfgDelay;
               mdlState = 1;
             end
          1: if (mdlCnt == 0) begin
               i2cReady = 1'b0;
               i2cNoAcknowledge = 1'b0;
               i2cClockStretchTimeoutReached = 1'b0;
               mdlCnt = cfgLen;
               mdlState = 2;
             end else mdlCnt--;
          default: if (mdlCnt == 0) begin
               i2cReady = 1'b1;
               i2cBytesToRead[23:0] = {cfgSec, cfgMin, cfgHr};
               i2cNoAcknowledge = cfgNack;
               i2cClockStretchTimeoutReached = cfgStretch;
               mdlState = 0;
             end else mdlCnt--;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    pollNow = 1'b0;
    repeat (4) tick();
    nTests++;
    if (obs() !== 21'h0 || busy !== 1'b0 || i2cStart !== 1'b0) begin
      nFail++;
      $display("FAIL reset_values: got %h busy=%b start=%b expected 0", obs(), busy, i2cStart);
    end
    nTests++;
    if (i2cAddress !== 7'h68 || i2cNrOfBytesToSend !== 5'd1 ||
        i2cBytesToSend !== 128'h0 || i2cNrOfBytesToRead !== 5'd3) begin
      nFail++;
      $display("FAIL const_cmd: got addr=%h nsend=%0d send=%h nread=%0d expected 68/1/0/3",
               i2cAddress, i2cNrOfBytesToSend, i2cBytesToSend, i2cNrOfBytesToRead);
    end
  endtask

  task automatic test_first_read();
    bit ok;
    int p0;
    logic [20:0] e;
    cfgSec = 8'h45; cfgMin = 8'h59; cfgHr = 8'h23; cfgDelay = 3; cfgLen = 10;
    sb.push_back(mkExp(45, 59, 23, 0, 1, 0, 0));
    p0 = pulseCount;
    reset = 1'b0;
    tick();
    nTests++;
    if (busy !== 1'b1 || i2cStart !== 1'b0) begin
      nFail++;
      $display("FAIL first_request: got busy=%b start=%b expected busy=1 start=0", busy, i2cStart);
    end
    tick();
    nTests++;
    if (i2cStart !== 1'b1) begin
      nFail++;
      $display("FAIL first_pulse: got start=%b expected 1", i2cStart);
    end
    wait_done(500, ok);
    nTests++;
    if (!ok) begin nFail++; $display("FAIL first_done: got timeout expected busy fall"); end
    e = sb.pop_front();
    nTests++;
    if (obs() !== e) begin nFail++; $display("FAIL first_txn: got %h expected %h", obs(), e); end
    nTests++;
    if (pulseCount != p0 + 1) begin
      nFail++;
      $display("FAIL first_pulse_count: got %0d expected %0d", pulseCount - p0, 1);
    end
    curS = 45; curM = 59; curH = 23; curHalt = 0;
  endtask

  task automatic test_bus_errors();
    bit ok;
    logic [20:0] e;
    // NACK, recovery, stretch timeout, recovery
    for (int i = 0; i < 4; i++) begin
      cfgNack    = (i == 0);
      cfgStretch = (i == 2);
      cfgSec = (i == 1) ? 8'h30 : 8'h11;
      cfgMin = (i == 1) ? 8'h15 : 8'h22;
      cfgHr  = (i == 1) ? 8'h08 : 8'h03;
      if (i == 3) begin cfgSec = 8'h01; cfgMin = 8'h02; cfgHr = 8'h03; end
      if (i == 1) begin curS = 30; curM = 15; curH = 8; end
      if (i == 3) begin curS = 1;  curM = 2;  curH = 3; end
      sb.push_back(mkExp(curS, curM, curH, curHalt, (i % 2) == 1, (i % 2) == 0, 0));
      poll_now();
      wait_done(500, ok);
      nTests++;
      if (!ok) begin nFail++; $display("FAIL bus_err_done[%0d]: got timeout expected busy fall", i); end
      e = sb.pop_front();
      nTests++;
      if (obs() !== e) begin nFail++; $display("FAIL bus_err[%0d]: got %h expected %h", i, obs(), e); end
    end
    cfgNack = 0; cfgStretch = 0;
  endtask

  typedef struct {
    logic [7:0] s, m, h;
    bit         valid;
    int         es, em, eh;
    bit         halt;
  } row_t;

  task automatic test_data_decode();
    bit ok;
    logic [20:0] e;
    row_t tbl[10];
    tbl[0] = '{8'hC5, 8'h00, 8'h00, 1, 45, 0, 0, 1};
    tbl[1] = '{8'h5A, 8'h10, 8'h10, 0, 0, 0, 0, 0};
    tbl[2] = '{8'h00, 8'h00, 8'h45, 0, 0, 0, 0, 0};
    tbl[3] = '{8'h60, 8'h00, 8'h00, 0, 0, 0, 0, 0};
    tbl[4] = '{8'h00, 8'h60, 8'h00, 0, 0, 0, 0, 0};
    tbl[5] = '{8'h00, 8'h00, 8'h24, 0, 0, 0, 0, 0};
    tbl[6] = '{8'h00, 8'h0A, 8'h00, 0, 0, 0, 0, 0};
    tbl[7] = '{8'h59, 8'hD9, 8'hA3, 1, 59, 59, 23, 0};
    tbl[8] = '{8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0};
    tbl[9] = '{8'h80, 8'h07, 8'h19, 1, 0, 7, 19, 1};
    foreach (tbl[i]) begin
      cfgSec = tbl[i].s; cfgMin = tbl[i].m; cfgHr = tbl[i].h;
      if (tbl[i].valid) begin
        curS = tbl[i].es; curM = tbl[i].em; curH = tbl[i].eh; curHalt = tbl[i].halt;
        sb.push_back(mkExp(curS, curM, curH, curHalt, 1, 0, 0));
      end else begin
        sb.push_back(mkExp(curS, curM, curH, curHalt, 0, 0, 1));
      end
      poll_now();
      wait_done(500, ok);
      nTests++;
      if (!ok) begin nFail++; $display("FAIL decode_done[%0d]: got timeout expected busy fall", i); end
      e = sb.pop_front();
      nTests++;
      if (obs() !== e) begin nFail++; $display("FAIL decode[%0d]: got %h expected %h", i, obs(), e); end
    end
  endtask

  task automatic test_start_timeout();
    bit ok;
    logic [20:0] e;
    cfgNoBusy = 1;
    sb.push_back(mkExp(curS, curM, curH, curHalt, 0, 1, 0));
    poll_now();
    wait_done(5000, ok);
    nTests++;
    if (!ok) begin nFail++; $display("FAIL timeout_done: got no return to idle expected idle"); end
    nTests++;
    if (cyc - lastPulseCyc != 3000) begin
      nFail++;
      $display("FAIL timeout_len: got %0d cycles expected 3000", cyc - lastPulseCyc);
    end
    e = sb.pop_front();
    nTests++;
    if (obs() !== e) begin nFail++; $display("FAIL timeout_txn: got %h expected %h", obs(), e); end
    cfgNoBusy = 0;
  endtask

  task automatic test_poll_period();
    bit ok;
    int i0, p0;
    logic [20:0] e;
    for (int k = 0; k < 2; k++) begin
      cfgSec = 8'h12; cfgMin = 8'h34; cfgHr = (k == 0) ? 8'h05 : 8'h06;
      curS = 12; curM = 34; curH = (k == 0) ? 5 : 6; curHalt = 0;
      sb.push_back(mkExp(curS, curM, curH, 0, 1, 0, 0));
      i0 = lastIdleCyc;
      p0 = pulseCount;
      wait_pulse(p0, 2500);
      nTests++;
      if (pulseCount == p0 || lastPulseCyc - i0 != 2001) begin
        nFail++;
        $display("FAIL poll_period[%0d]: got %0d cycles expected 2001", k, lastPulseCyc - i0);
      end
      wait_done(500, ok);
      nTests++;
      if (!ok) begin nFail++; $display("FAIL poll_done[%0d]: got timeout expected busy fall", k); end
      e = sb.pop_front();
      nTests++;
      if (obs() !== e) begin nFail++; $display("FAIL poll_txn[%0d]: got %h expected %h", k, obs(), e); end
    end
  endtask

  task automatic test_poll_now();
    bit ok;
    int c0, p0, n, iIdle;
    logic [20:0] e;
    cfgSec = 8'h07; cfgMin = 8'h08; cfgHr = 8'h09; cfgLen = 30;
    curS = 7; curM = 8; curH = 9; curHalt = 0;
    sb.push_back(mkExp(7, 8, 9, 0, 1, 0, 0));
    c0 = cyc;
    p0 = pulseCount;
    poll_now();
    wait_pulse(p0, 10);
    nTests++;
    if (lastPulseCyc != c0 + 2) begin
      nFail++;
      $display("FAIL pollnow_latency: got %0d expected %0d", lastPulseCyc - c0, 2);
    end
    n = 0;
    while (i2cReady && n < 50) begin tick(); n++; end
    poll_now();                      // issued while busy: must be dropped
    wait_done(500, ok);
    e = sb.pop_front();
    nTests++;
    if (!ok || obs() !== e) begin nFail++; $display("FAIL pollnow_txn: got %h ok=%b expected %h", obs(), ok, e); end
    repeat (20) tick();
    nTests++;
    if (pulseCount != p0 + 1) begin
      nFail++;
      $display("FAIL pollnow_busy_ignored: got %0d pulses expected 1", pulseCount - p0);
    end
    // pollNow in the same cycle the poll counter hits zero
    iIdle = lastIdleCyc;
    p0 = pulseCount;
    sb.push_back(mkExp(7, 8, 9, 0, 1, 0, 0));
    while (cyc < iIdle + 1999) tick();
    poll_now();
    wait_pulse(p0, 10);
    nTests++;
    if (lastPulseCyc != iIdle + 2001) begin
      nFail++;
      $display("FAIL coincident_pulse: got %0d expected %0d", lastPulseCyc - iIdle, 2001);
    end
    wait_done(500, ok);
    e = sb.pop_front();
    nTests++;
    if (!ok || obs() !== e) begin nFail++; $display("FAIL coincident_txn: got %h ok=%b expected %h", obs(), ok, e); end
    repeat (20) tick();
    nTests++;
    if (pulseCount != p0 + 1) begin
      nFail++;
      $display("FAIL coincident_count: got %0d pulses expected 1", pulseCount - p0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    logic [20:0] e;
    cfgSec = 8'h21; cfgMin = 8'h43; cfgHr = 8'h11; cfgLen = 40; cfgDelay = 1;
    poll_now();
    n = 0;
    while (i2cReady && n < 50) begin tick(); n++; end
    repeat (3) tick();
    reset = 1'b1;
    tick();
    nTests++;
    if (busy !== 1'b0 || i2cStart !== 1'b0 || obs() !== 21'h0) begin
      nFail++;
      $display("FAIL reset_mid: got busy=%b start=%b out=%h expected 0/0/0", busy, i2cStart, obs());
    end
    tick();
    sb.push_back(mkExp(21, 43, 11, 0, 1, 0, 0));
    reset = 1'b0;
    tick();
    tick();
    nTests++;
    if (i2cStart !== 1'b1) begin
      nFail++;
      $display("FAIL reset_mid_restart: got start=%b expected 1", i2cStart);
    end
    wait_done(500, ok);
    e = sb.pop_front();
    nTests++;
    if (!ok || obs() !== e) begin nFail++; $display("FAIL reset_mid_txn: got %h ok=%b expected %h", obs(), ok, e); end
  endtask

  initial begin
    reset = 1'b1;
    pollNow = 1'b0;
    test_reset();
    test_first_read();
    test_bus_errors();
    test_data_decode();
    test_start_timeout();
    test_poll_period();
    test_poll_now();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
